// File: rtl/xalu_ise_arb.sv
// Two-requester arbiter/sequencer in front of the shared Xoodyak ISE ALU.
// One operation in flight: IDLE accepts, EXEC drives the ALU, RESP returns the result.
module xalu_ise_arb #(
    parameter int XLEN  = 64,
    parameter bit RR_EN = 1'b1
) (
    input  logic            ise_clk,
    input  logic            ise_rst,
    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [4:0]      r0_fn,
    input  logic [6:0]      r0_imm,
    input  logic [XLEN-1:0] r0_in1,
    input  logic [XLEN-1:0] r0_in2,
    output logic            r0_rsp_valid,
    input  logic            r0_rsp_ready,
    output logic [XLEN-1:0] r0_rsp_data,
    output logic            r0_rsp_err,
    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [4:0]      r1_fn,
    input  logic [6:0]      r1_imm,
    input  logic [XLEN-1:0] r1_in1,
    input  logic [XLEN-1:0] r1_in2,
    output logic            r1_rsp_valid,
    input  logic            r1_rsp_ready,
    output logic [XLEN-1:0] r1_rsp_data,
    output logic            r1_rsp_err,
    output logic [4:0]      x_fn,
    output logic [6:0]      x_imm,
    output logic [XLEN-1:0] x_in1,
    output logic [XLEN-1:0] x_in2,
    output logic            x_val,
    input  logic            x_oval,
    input  logic [XLEN-1:0] x_out
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic            last_grant;
    logic            grant;
    logic            sel;
    logic            idle;
    logic            exec;
    logic            rsp_done;
    logic [4:0]      op_fn;
    logic [6:0]      op_imm;
    logic [XLEN-1:0] op_in1;
    logic [XLEN-1:0] op_in2;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    // Requester 1 wins only when alone, or on its round-robin turn.
    always_comb begin
        sel = r1_valid;
        if (r0_valid && r1_valid)
            sel = RR_EN ? ~last_grant : 1'b0;
    end

    assign idle     = (state == IDLE) && !ise_rst;
    assign exec     = (state == EXEC);
    assign r0_ready = idle && r0_valid && !sel;
    assign r1_ready = idle && r1_valid && sel;
    assign rsp_done = grant ? r1_rsp_ready : r0_rsp_ready;

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            op_fn      <= '0;
            op_imm     <= '0;
            op_in1     <= '0;
            op_in2     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (r0_ready || r1_ready) begin
                    grant  <= sel;
                    op_fn  <= sel ? r1_fn  : r0_fn;
                    op_imm <= sel ? r1_imm : r0_imm;
                    op_in1 <= sel ? r1_in1 : r0_in1;
                    op_in2 <= sel ? r1_in2 : r0_in2;
                    state  <= EXEC;
                end
                EXEC: begin
                    rsp_data <= x_oval ? x_out : '0;
                    rsp_err  <= ~x_oval;
                    state    <= RESP;
                end
                RESP: if (rsp_done) begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ALU inputs are held at zero outside the execute cycle.
    assign x_val = exec;
    assign x_fn  = exec ? op_fn  : '0;
    assign x_imm = exec ? op_imm : '0;
    assign x_in1 = exec ? op_in1 : '0;
    assign x_in2 = exec ? op_in2 : '0;

    assign r0_rsp_valid = (state == RESP) && !grant;
    assign r1_rsp_valid = (state == RESP) && grant;
    assign r0_rsp_data  = r0_rsp_valid ? rsp_data : '0;
    assign r1_rsp_data  = r1_rsp_valid ? rsp_data : '0;
    assign r0_rsp_err   = r0_rsp_valid && rsp_err;
    assign r1_rsp_err   = r1_rsp_valid && rsp_err;
endmodule

// File: tb/tb_xalu_ise_arb.sv
// Bench for xalu_ise_arb: ALU stub, transaction-level reference model checked
// every cycle, directed scenarios followed by randomized traffic.
module tb_xalu_ise_arb;
    logic        ise_clk, ise_rst;
    logic        r0_valid, r1_valid, r0_rsp_ready, r1_rsp_ready;
    logic [4:0]  r0_fn, r1_fn;
    logic [6:0]  r0_imm, r1_imm;
    logic [63:0] r0_in1, r0_in2, r1_in1, r1_in2;

    logic        r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err;
    logic [63:0] r0_rsp_data, r1_rsp_data;
    logic [4:0]  x_fn;
    logic [6:0]  x_imm;
    logic [63:0] x_in1, x_in2, x_out;
    logic        x_val, x_oval;

    logic        f_r0_ready, f_r1_ready, f_r0_rsp_valid, f_r1_rsp_valid, f_r0_rsp_err, f_r1_rsp_err;
    logic [63:0] f_r0_rsp_data, f_r1_rsp_data;
    logic [4:0]  f_x_fn;
    logic [6:0]  f_x_imm;
    logic [63:0] f_x_in1, f_x_in2, f_x_out;
    logic        f_x_val, f_x_oval;

    int n_chk = 0, n_err = 0;

    // ALU stub: fn[1:0] 0=roli, 1=roliw, 2=andn, 3=unrecognised.
    function automatic logic [64:0] alu_ref(input logic [4:0] fn, input logic [6:0] imm,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [31:0] w;
        case (fn[1:0])
            2'd0: return {1'b1, (a << imm[5:0]) | (a >> (7'd64 - {1'b0, imm[5:0]}))};
            2'd1: begin
                w = a[31:0];
                w = (w << imm[4:0]) | (w >> (6'd32 - {1'b0, imm[4:0]}));
                return {1'b1, {32{w[31]}}, w};
            end
            2'd2: return {1'b1, a & ~b};
            default: return 65'd0;
        endcase
    endfunction

    assign {x_oval, x_out}     = x_val   ? alu_ref(x_fn, x_imm, x_in1, x_in2)         : 65'd0;
    assign {f_x_oval, f_x_out} = f_x_val ? alu_ref(f_x_fn, f_x_imm, f_x_in1, f_x_in2) : 65'd0;

    xalu_ise_arb #(.XLEN(64), .RR_EN(1'b1)) dut (
        .ise_clk(ise_clk), .ise_rst(ise_rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_fn(r0_fn), .r0_imm(r0_imm),
        .r0_in1(r0_in1), .r0_in2(r0_in2), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_fn(r1_fn), .r1_imm(r1_imm),
        .r1_in1(r1_in1), .r1_in2(r1_in2), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
        .x_fn(x_fn), .x_imm(x_imm), .x_in1(x_in1), .x_in2(x_in2), .x_val(x_val),
        .x_oval(x_oval), .x_out(x_out)
    );

    xalu_ise_arb #(.XLEN(64), .RR_EN(1'b0)) dut_fp (
        .ise_clk(ise_clk), .ise_rst(ise_rst),
        .r0_valid(r0_valid), .r0_ready(f_r0_ready), .r0_fn(r0_fn), .r0_imm(r0_imm),
        .r0_in1(r0_in1), .r0_in2(r0_in2), .r0_rsp_valid(f_r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(f_r0_rsp_data), .r0_rsp_err(f_r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(f_r1_ready), .r1_fn(r1_fn), .r1_imm(r1_imm),
        .r1_in1(r1_in1), .r1_in2(r1_in2), .r1_rsp_valid(f_r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(f_r1_rsp_data), .r1_rsp_err(f_r1_rsp_err),
        .x_fn(f_x_fn), .x_imm(f_x_imm), .x_in1(f_x_in1), .x_in2(f_x_in2), .x_val(f_x_val),
        .x_oval(f_x_oval), .x_out(f_x_out)
    );

    initial ise_clk = 1'b0;
    always #5 ise_clk = ~ise_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: one op in flight, age counts cycles since accept.
    bit          m_busy = 0, m_owner = 0, m_last = 1;
    int          m_age = 0, m_done = 0, dut_rsps = 0;
    logic [4:0]  m_fn;
    logic [6:0]  m_imm;
    logic [63:0] m_in1, m_in2, m_data;
    bit          m_err;
    int          grants_q[$];

    always @(negedge ise_clk) begin
        bit sel, e0, e1, exv;
        logic [64:0] r;
        if (ise_rst) begin
            m_busy = 0;
            m_last = 1;
            chk("rst_ready", {62'd0, r0_ready, r1_ready}, 64'd0);
            chk("rst_rsp_valid", {62'd0, r0_rsp_valid, r1_rsp_valid}, 64'd0);
            chk("rst_x_val", {63'd0, x_val}, 64'd0);
            chk("rst_data", r0_rsp_data | r1_rsp_data | x_in1 | x_in2, 64'd0);
        end else begin
            sel = (r0_valid && r1_valid) ? ~m_last : r1_valid;
            e0  = !m_busy && r0_valid && !sel;
            e1  = !m_busy && r1_valid && sel;
            exv = m_busy && m_age == 1;
            chk("r0_ready", {63'd0, r0_ready}, {63'd0, e0});
            chk("r1_ready", {63'd0, r1_ready}, {63'd0, e1});
            chk("x_val", {63'd0, x_val}, {63'd0, exv});
            chk("r0_rsp_valid", {63'd0, r0_rsp_valid}, {63'd0, m_busy && m_age >= 2 && !m_owner});
            chk("r1_rsp_valid", {63'd0, r1_rsp_valid}, {63'd0, m_busy && m_age >= 2 && m_owner});
            chk("fp_prio", {63'd0, r0_valid && f_r1_ready}, 64'd0);
            if (exv) begin
                chk("x_in1", x_in1, m_in1);
                chk("x_in2", x_in2, m_in2);
                chk("x_fn_imm", 64'({x_fn, x_imm}), 64'({m_fn, m_imm}));
            end else begin
                chk("x_quiet", x_in1 | x_in2 | 64'({x_fn, x_imm}), 64'd0);
            end
            if (m_busy && m_age >= 2) begin
                chk("rsp_data", m_owner ? r1_rsp_data : r0_rsp_data, m_data);
                chk("rsp_err", {63'd0, m_owner ? r1_rsp_err : r0_rsp_err}, {63'd0, m_err});
            end
            if (r0_rsp_valid && r0_rsp_ready) dut_rsps++;
            if (r1_rsp_valid && r1_rsp_ready) dut_rsps++;
            // advance to the state after the coming rising edge
            if (!m_busy) begin
                if (e0 || e1) begin
                    m_busy = 1; m_age = 1; m_owner = sel;
                    m_fn  = sel ? r1_fn  : r0_fn;
                    m_imm = sel ? r1_imm : r0_imm;
                    m_in1 = sel ? r1_in1 : r0_in1;
                    m_in2 = sel ? r1_in2 : r0_in2;
                    r = alu_ref(m_fn, m_imm, m_in1, m_in2);
                    m_err  = !r[64];
                    m_data = r[64] ? r[63:0] : 64'd0;
                    grants_q.push_back(int'(sel));
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (m_owner ? r1_rsp_ready : r0_rsp_ready) begin
                m_busy = 0; m_last = m_owner; m_done++;
            end
        end
    end

    task automatic step();
        @(posedge ise_clk);
        #1;
    endtask

    task automatic wait_ready(input bit who);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ise_clk);
            if (who ? r1_ready : r0_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge ise_clk);
        #1;
    endtask

    initial begin
        logic [64:0] t;
        logic [63:0] held;
        int start;
        r0_valid = 0; r1_valid = 0; r0_rsp_ready = 0; r1_rsp_ready = 0;
        r0_fn = 0; r1_fn = 0; r0_imm = 0; r1_imm = 0;
        r0_in1 = 0; r0_in2 = 0; r1_in1 = 0; r1_in2 = 0;
        ise_rst = 1;
        t = alu_ref(5'd0, 7'd1, 64'h8000_0000_0000_0001, 64'd0);
        chk("ref_roli", t[63:0], 64'h3);
        t = alu_ref(5'd2, 7'd0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        chk("ref_andn", t[63:0], 64'h00F0_00F0_00F0_00F0);
        t = alu_ref(5'd1, 7'd1, 64'h0000_0000_C000_0000, 64'd0);
        chk("ref_roliw", t[63:0], 64'hFFFF_FFFF_8000_0001);
        repeat (2) step();
        chk("rst_rsp_data", r0_rsp_data, 64'd0);
        ise_rst = 0;

        // roli by 1, result two cycles after accept
        step();
        r0_valid = 1; r0_fn = 5'd0; r0_imm = 7'h01; r0_in1 = 64'h8000_0000_0000_0001;
        wait_ready(0);
        r0_valid = 0;
        @(negedge ise_clk);
        chk("t1_x_val", {63'd0, x_val}, 64'd1);
        chk("t1_x_in1", x_in1, 64'h8000_0000_0000_0001);
        @(negedge ise_clk);
        chk("t1_rsp_valid", {63'd0, r0_rsp_valid}, 64'd1);
        chk("t1_rsp_data", r0_rsp_data, 64'h3);
        chk("t1_rsp_err", {63'd0, r0_rsp_err}, 64'd0);
        step(); r0_rsp_ready = 1; step(); r0_rsp_ready = 0;

        // unrecognised op on r1
        r1_valid = 1; r1_fn = 5'b00011; r1_imm = 7'h22; r1_in1 = 64'h1234;
        wait_ready(1);
        r1_valid = 0;
        repeat (2) @(negedge ise_clk);
        chk("t3_rsp_valid", {63'd0, r1_rsp_valid}, 64'd1);
        chk("t3_rsp_err", {63'd0, r1_rsp_err}, 64'd1);
        chk("t3_rsp_data", r1_rsp_data, 64'd0);
        step(); r1_rsp_ready = 1; step(); r1_rsp_ready = 0;

        // r0 response stalled while r1 waits
        r0_valid = 1; r0_fn = 5'd2; r0_in1 = 64'hDEAD_BEEF_0000_FFFF; r0_in2 = 64'h0000_FFFF_0000_00F0;
        wait_ready(0);
        r0_valid = 0; r1_valid = 1; r1_fn = 5'd2; r1_in1 = 64'h55; r1_in2 = 64'h5;
        repeat (2) @(negedge ise_clk);
        held = r0_rsp_data;
        chk("t4_data", held, 64'hDEAD_0000_0000_FF0F);
        for (int i = 0; i < 10; i++) begin
            @(negedge ise_clk);
            chk("t4_r1_blocked", {63'd0, r1_ready}, 64'd0);
            chk("t4_stable", r0_rsp_data, held);
        end
        step(); r0_rsp_ready = 1; step(); r0_rsp_ready = 0;
        @(negedge ise_clk);
        chk("t4_r1_next", {63'd0, r1_ready}, 64'd1);
        step(); r1_valid = 0; r1_rsp_ready = 1;
        repeat (3) step();

        // both valid continuously: strict alternation starting at r0
        start = grants_q.size();
        r0_valid = 1; r1_valid = 1; r0_rsp_ready = 1; r1_rsp_ready = 1;
        r0_fn = 5'd2; r1_fn = 5'd2;
        for (int i = 0; i < 16; i++) begin
            r0_in1 = {$urandom, $urandom}; r0_in2 = {$urandom, $urandom};
            r1_in1 = {$urandom, $urandom}; r1_in2 = {$urandom, $urandom};
            step();
        end
        chk("t2_grant_cnt", 64'(grants_q.size() - start >= 4), 64'd1);
        for (int i = start; i < grants_q.size(); i++)
            chk("t2_alternate", 64'(grants_q[i]), 64'((i - start) % 2));
        r0_valid = 0; r1_valid = 0;
        repeat (4) step();

        // reset during EXEC, then during RESP
        r0_rsp_ready = 0;
        r0_valid = 1; r0_fn = 5'd2; r0_in1 = 64'hFF;
        wait_ready(0);
        chk("t5_exec_before", {63'd0, x_val}, 64'd1);
        #1 ise_rst = 1; r0_valid = 0;
        #1 chk("t5_exec_rst", {61'd0, x_val, r0_rsp_valid, r0_ready}, 64'd0);
        step(); ise_rst = 0;
        r0_valid = 1;
        wait_ready(0);
        r0_valid = 0;
        step();
        chk("t5_resp_before", {63'd0, r0_rsp_valid}, 64'd1);
        #1 ise_rst = 1;
        #1 chk("t5_resp_rst", {62'd0, r0_rsp_valid, x_val}, 64'd0);
        chk("t5_resp_data", r0_rsp_data, 64'd0);
        step(); ise_rst = 0;
        start = grants_q.size();
        r0_valid = 1; r1_valid = 1; r0_rsp_ready = 1; r1_rsp_ready = 1;
        step();
        r0_valid = 0; r1_valid = 0;
        chk("t5_first_grant", 64'(grants_q.size() > start ? grants_q[start] : 9), 64'd0);
        repeat (6) step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            r0_valid = ($urandom_range(0, 9) < 6); r1_valid = ($urandom_range(0, 9) < 6);
            r0_rsp_ready = $urandom_range(0, 1); r1_rsp_ready = $urandom_range(0, 1);
            r0_fn = 5'($urandom); r1_fn = 5'($urandom);
            r0_imm = 7'($urandom); r1_imm = 7'($urandom);
            r0_in1 = {$urandom, $urandom}; r0_in2 = {$urandom, $urandom};
            r1_in1 = {$urandom, $urandom}; r1_in2 = {$urandom, $urandom};
            step();
        end
        r0_valid = 0; r1_valid = 0; r0_rsp_ready = 1; r1_rsp_ready = 1;
        repeat (6) step();
        chk("rsp_count", 64'(dut_rsps), 64'(m_done));
        chk("drained", {62'd0, r0_rsp_valid, r1_rsp_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
